// File: rtl/soft_recursion_engine_if.sv
// Bus bundle for soft_recursion_engine: run request, strand configuration,
// addressed readout and status. clk/rst_n are kept outside the bundle.
interface soft_recursion_engine_if #(
   parameter int MAX_N = 6,
   parameter int MAX_L = 12,
   parameter int A     = 9,
   parameter int CNT_W = 32
);
   localparam int NW = $clog2(MAX_N + 1);
   localparam int LW = $clog2(MAX_L + 1);
   localparam int SW = (A > 1) ? $clog2(A) : 1;

   logic             start;
   logic [MAX_N-1:0] strand;
   logic [NW-1:0]    n_len;
   logic [LW-1:0]    l_len;
   logic [NW-1:0]    rd_j;
   logic [SW-1:0]    rd_s;
   logic [CNT_W-1:0] rd_data;
   logic             busy;
   logic             done;
   logic             result_valid;
   logic             overflow;
   logic             err;

   modport master (
      output start, strand, n_len, l_len, rd_j, rd_s,
      input  rd_data, busy, done, result_valid, overflow, err
   );

   modport slave (
      input  start, strand, n_len, l_len, rd_j, rd_s,
      output rd_data, busy, done, result_valid, overflow, err
   );
endinterface

// File: rtl/soft_recursion_engine.sv
// soft_recursion_engine: forward recursion over codeword length, counting
// length-L words whose greedy leftmost embedding of strand y consumes j
// symbols, binned by weighted syndrome sum(k*x_k) mod A.
// Optional feature: define SOFT_REC_SAT_EN for saturating counters
// (default build wraps modulo 2^CNT_W; overflow flags either way).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; result of last run held on readout
// S_CLEAR | zero the nxt bank before a sweep
// S_SWEEP | one (j,s) cell of cur per cycle scattered into nxt
// S_SWAP  | cur <= nxt, advance symbol index i and weight w
// S_DONE  | one-cycle completion pulse
module soft_recursion_engine #(
   parameter int MAX_N = 6,
   parameter int MAX_L = 12,
   parameter int A     = 9,
   parameter int CNT_W = 32
) (
   input logic                    clk,
   input logic                    rst_n,
   soft_recursion_engine_if.slave bus
);
   localparam int NW = $clog2(MAX_N + 1);
   localparam int LW = $clog2(MAX_L + 1);
   localparam int SW = (A > 1) ? $clog2(A) : 1;

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SWEEP, S_SWAP, S_DONE} state_t;
   state_t state_q, state_d;

   logic [MAX_N-1:0] strand_q;
   logic [NW-1:0]    n_q, j_q;
   logic [LW-1:0]    l_q, i_q, i_inc;
   logic [SW-1:0]    s_q, w_q, s1;
   logic [SW:0]      s_sum;
   logic [NW-1:0]    j0, j1;
   logic             err_q, ovf_q, rv_q;
   logic             bad_cfg, sweep_last, ovf_add;
   logic [CNT_W-1:0] c;
   logic [CNT_W:0]   r0, r1;
   logic [CNT_W-1:0] cur_q [0:MAX_N][0:A-1];
   logic [CNT_W-1:0] nxt_q [0:MAX_N][0:A-1];
   logic [CNT_W-1:0] nxt_d [0:MAX_N][0:A-1];

   // Top bit of the result is the carry out; low bits are the stored value.
   function automatic logic [CNT_W:0] add_cnt(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
`ifdef SOFT_REC_SAT_EN
      if (sum[CNT_W]) sum[CNT_W-1:0] = '1;
`endif
      return sum;
   endfunction

   assign bad_cfg    = (int'(bus.n_len) > MAX_N) || (int'(bus.l_len) > MAX_L);
   assign sweep_last = (j_q == n_q) && (int'(s_q) == A - 1);
   assign i_inc      = i_q + LW'(1);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = (bad_cfg || bus.l_len == '0) ? S_DONE : S_CLEAR;
         S_CLEAR: state_d = S_SWEEP;
         S_SWEEP: if (sweep_last) state_d = S_SWAP;
         S_SWAP:  state_d = (i_inc < l_q) ? S_CLEAR : S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      bus.busy = (state_q == S_CLEAR) || (state_q == S_SWEEP) || (state_q == S_SWAP);
      bus.done = (state_q == S_DONE);
   end

   // Scatter targets for the current cell: b=0 keeps s, b=1 adds w mod A
   always_comb begin
      j0 = j_q;
      j1 = j_q;
      if (j_q < n_q) begin
         if (strand_q[j_q]) j1 = j_q + NW'(1);
         else               j0 = j_q + NW'(1);
      end
      s_sum = {1'b0, s_q} + {1'b0, w_q};
      if (int'(s_sum) >= A) s_sum = s_sum - (SW+1)'(A);
      s1 = s_sum[SW-1:0];
   end

   // nxt bank update; coincident targets (j=N, w=0) receive the cell twice
   always_comb begin
      nxt_d   = nxt_q;
      ovf_add = 1'b0;
      r0      = '0;
      r1      = '0;
      c       = cur_q[j_q][s_q];
      if (state_q == S_CLEAR) begin
         for (int jj = 0; jj <= MAX_N; jj++)
            for (int ss = 0; ss < A; ss++)
               nxt_d[jj][ss] = '0;
      end else if (state_q == S_SWEEP) begin
         r0 = add_cnt(nxt_q[j0][s_q], c);
         if (j0 == j1 && s_q == s1) begin
            r1 = add_cnt(r0[CNT_W-1:0], c);
            nxt_d[j0][s_q] = r1[CNT_W-1:0];
         end else begin
            r1 = add_cnt(nxt_q[j1][s1], c);
            nxt_d[j0][s_q] = r0[CNT_W-1:0];
            nxt_d[j1][s1]  = r1[CNT_W-1:0];
         end
         ovf_add = r0[CNT_W] | r1[CNT_W];
      end
   end

   // Datapath registers: run latch, counters, banks, sticky status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strand_q <= '0;
         n_q      <= '0;
         l_q      <= '0;
         i_q      <= '0;
         j_q      <= '0;
         s_q      <= '0;
         w_q      <= '0;
         err_q    <= 1'b0;
         ovf_q    <= 1'b0;
         rv_q     <= 1'b0;
         for (int jj = 0; jj <= MAX_N; jj++)
            for (int ss = 0; ss < A; ss++) begin
               cur_q[jj][ss] <= '0;
               nxt_q[jj][ss] <= '0;
            end
      end else begin
         nxt_q <= nxt_d;
         case (state_q)
            S_IDLE: if (bus.start) begin
               strand_q <= bus.strand;
               n_q      <= bus.n_len;
               l_q      <= bus.l_len;
               err_q    <= bad_cfg;
               ovf_q    <= 1'b0;
               rv_q     <= 1'b0;
               i_q      <= '0;
               w_q      <= SW'((A > 1) ? 1 : 0);
               for (int jj = 0; jj <= MAX_N; jj++)
                  for (int ss = 0; ss < A; ss++)
                     cur_q[jj][ss] <= (jj == 0 && ss == 0) ? CNT_W'(1) : '0;
            end
            S_CLEAR: begin
               j_q <= '0;
               s_q <= '0;
            end
            S_SWEEP: begin
               ovf_q <= ovf_q | ovf_add;
               if (int'(s_q) == A - 1) begin
                  s_q <= '0;
                  j_q <= j_q + NW'(1);
               end else begin
                  s_q <= s_q + SW'(1);
               end
            end
            S_SWAP: begin
               cur_q <= nxt_q;
               i_q   <= i_inc;
               w_q   <= (int'(w_q) == A - 1) ? '0 : w_q + SW'(1);
            end
            default: ;
         endcase
         if (state_d == S_DONE && state_q != S_DONE)
            rv_q <= (state_q == S_IDLE) ? !bad_cfg : !err_q;
      end
   end

   // Status outputs
   assign bus.result_valid = rv_q;
   assign bus.overflow     = ovf_q;
   assign bus.err          = err_q;

   // Addressed readout, zero outside the valid result window
   always_comb begin
      bus.rd_data = '0;
      if (rv_q && bus.rd_j <= n_q && int'(bus.rd_s) < A)
         bus.rd_data = cur_q[bus.rd_j][bus.rd_s];
   end
endmodule

// File: tb/tb_soft_recursion_engine.sv
`timescale 1ns/1ps
module tb_soft_recursion_engine;
   localparam int MAX_N = 6, MAX_L = 12, A = 9, CNT_W = 32;
   localparam int NW = 3, LW = 4, SW = 4;
   localparam int SMAX_N = 2, SMAX_L = 8, SA = 1, SCW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   soft_recursion_engine_if #(.MAX_N(MAX_N), .MAX_L(MAX_L), .A(A), .CNT_W(CNT_W)) bus ();
   soft_recursion_engine_if #(.MAX_N(SMAX_N), .MAX_L(SMAX_L), .A(SA), .CNT_W(SCW)) sbus ();

   soft_recursion_engine #(.MAX_N(MAX_N), .MAX_L(MAX_L), .A(A), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave));
   soft_recursion_engine #(.MAX_N(SMAX_N), .MAX_L(SMAX_L), .A(SA), .CNT_W(SCW)) sdut (
      .clk(clk), .rst_n(rst_n), .bus(sbus.slave));

   typedef struct { int done_at; logic err; logic rv; logic ovf; } done_exp_t;
   typedef struct { string name; int kind; logic [31:0] val; } rd_exp_t;

   done_exp_t q_done[$], q_sdone[$];
   rd_exp_t   q_rd[$], q_srd[$];
   int n_vec = 0, n_bad = 0, cyc = 0;
   logic rd_req = 1'b0, srd_req = 1'b0;
   logic [31:0] acc = '0;
   done_exp_t md;
   rd_exp_t   mr;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s", name);
   endtask

   // Monitor: done pulses and readout strobes, compared against queued expectations
   always @(negedge clk) begin
      if (bus.done) begin
         if (q_done.size() == 0) fail("main unexpected done");
         else begin
            md = q_done.pop_front();
            chk("main done cycle", cyc, md.done_at);
            chk("main err", {31'd0, bus.err}, {31'd0, md.err});
            chk("main result_valid", {31'd0, bus.result_valid}, {31'd0, md.rv});
            chk("main overflow", {31'd0, bus.overflow}, {31'd0, md.ovf});
            chk("main busy in done", {31'd0, bus.busy}, 32'd0);
         end
      end
      if (sbus.done) begin
         if (q_sdone.size() == 0) fail("small unexpected done");
         else begin
            md = q_sdone.pop_front();
            chk("small done cycle", cyc, md.done_at);
            chk("small err", {31'd0, sbus.err}, {31'd0, md.err});
            chk("small result_valid", {31'd0, sbus.result_valid}, {31'd0, md.rv});
            chk("small overflow", {31'd0, sbus.overflow}, {31'd0, md.ovf});
         end
      end
      if (rd_req) begin
         if (q_rd.size() == 0) fail("main readout without expectation");
         else begin
            mr = q_rd.pop_front();
            if (mr.kind == 0) chk(mr.name, bus.rd_data, mr.val);
            else begin
               acc = acc + bus.rd_data;
               if (mr.kind == 2) begin
                  chk(mr.name, acc, mr.val);
                  acc = '0;
               end
            end
         end
      end
      if (srd_req) begin
         if (q_srd.size() == 0) fail("small readout without expectation");
         else begin
            mr = q_srd.pop_front();
            chk(mr.name, {28'd0, sbus.rd_data}, mr.val);
         end
      end
   end

   task automatic start_run(input int n, input int l, input logic [MAX_N-1:0] y, output int t0);
      @(posedge clk); #1;
      bus.strand = y;
      bus.n_len  = NW'(n);
      bus.l_len  = LW'(l);
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_done();
      int k = 0;
      while (!bus.done && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (!bus.done) begin
         fail("main done timeout");
         if (q_done.size() > 0) q_done.delete(q_done.size() - 1);
      end
   endtask

   // Expected completion follows L*((N+1)*A+2) cycles after the sampling edge
   task automatic push_done(input int t0, input int n, input int l, input logic e, input logic o);
      done_exp_t d;
      d.done_at = (e || l == 0) ? t0 : t0 + l * ((n + 1) * A + 2);
      d.err = e;
      d.rv  = !e;
      d.ovf = o;
      q_done.push_back(d);
   endtask

   task automatic run_main(input int n, input int l, input logic [MAX_N-1:0] y, input logic e);
      int t0;
      start_run(n, l, y, t0);
      push_done(t0, n, l, e, 1'b0);
      wait_done();
   endtask

   task automatic rd(input int j, input int s, input int kind, input logic [31:0] v, input string name);
      rd_exp_t r;
      @(posedge clk); #1;
      bus.rd_j = NW'(j);
      bus.rd_s = SW'(s);
      rd_req = 1'b1;
      r.name = name; r.kind = kind; r.val = v;
      q_rd.push_back(r);
   endtask

   task automatic rd_end();
      @(posedge clk); #1;
      rd_req = 1'b0;
   endtask

   task automatic check_t3(input string tag);
      logic [31:0] e;
      for (int j = 0; j <= 2; j++)
         for (int s = 0; s < 5; s++) begin
            e = ((j == 0 && s == 0) || (j == 1 && s >= 1 && s <= 3)) ? 32'd1 : 32'd0;
            rd(j, s, 0, e, $sformatf("%s rd(%0d,%0d)", tag, j, s));
         end
      rd_end();
   endtask

   initial begin
      int t0;
      logic [31:0] exp2 [0:8];
      rd_exp_t r;
      exp2 = '{1, 1, 1, 2, 1, 1, 1, 0, 0};
      bus.start = 0; bus.strand = '0; bus.n_len = '0; bus.l_len = '0; bus.rd_j = '0; bus.rd_s = '0;
      sbus.start = 0; sbus.strand = '0; sbus.n_len = '0; sbus.l_len = '0; sbus.rd_j = '0; sbus.rd_s = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", {31'd0, bus.busy}, 32'd0);
      chk("reset done", {31'd0, bus.done}, 32'd0);
      chk("reset result_valid", {31'd0, bus.result_valid}, 32'd0);
      chk("reset overflow", {31'd0, bus.overflow}, 32'd0);
      chk("reset err", {31'd0, bus.err}, 32'd0);
      chk("reset rd_data", bus.rd_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // L=0, N=0: unit cell only
      run_main(0, 0, '0, 1'b0);
      rd(0, 0, 0, 1, "t1 rd(0,0)");
      rd(0, 1, 0, 0, "t1 rd(0,1)");
      rd(0, 8, 0, 0, "t1 rd(0,8)");
      rd(1, 0, 0, 0, "t1 rd j>N");
      rd_end();

      // N=0, L=3: subset sums of weights {1,2,3}
      run_main(0, 3, '0, 1'b0);
      for (int s = 0; s < 9; s++) rd(0, s, 0, exp2[s], $sformatf("t2 rd(0,%0d)", s));
      rd(0, 9, 0, 0, "t2 rd s>=A");
      rd_end();

      // N=1, y=1, L=2
      run_main(1, 2, 6'b000001, 1'b0);
      check_t3("t3");

      // N=5, y=10101, L=5: only x=y reaches row 5, syndrome 9 mod 9 = 0
      run_main(5, 5, 6'b010101, 1'b0);
      for (int s = 0; s < 9; s++) rd(5, s, 0, (s == 0) ? 32'd1 : 32'd0, $sformatf("t4 rd(5,%0d)", s));
      for (int j = 0; j <= 5; j++)
         for (int s = 0; s < 9; s++)
            rd(j, s, (j == 5 && s == 8) ? 2 : 1, 32'd32, "t4 total count");
      rd_end();

      // Out-of-range lengths
      run_main(7, 2, '0, 1'b1);
      rd(0, 0, 0, 0, "err N readout gated");
      rd_end();
      run_main(1, 13, 6'b000001, 1'b1);
      rd(0, 0, 0, 0, "err L readout gated");
      rd_end();

      // start during busy is ignored
      start_run(1, 2, 6'b000001, t0);
      push_done(t0, 1, 2, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("busy mid-run", {31'd0, bus.busy}, 32'd1);
      bus.n_len = '0; bus.l_len = '0; bus.strand = '0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done();
      check_t3("ignored-start");

      // reset in the middle of a sweep
      start_run(5, 5, 6'b010101, t0);
      repeat (20) @(posedge clk);
      #1;
      bus.rd_j = '0; bus.rd_s = '0;
      rst_n = 1'b0;
      #1;
      chk("midrst busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst done", {31'd0, bus.done}, 32'd0);
      chk("midrst result_valid", {31'd0, bus.result_valid}, 32'd0);
      chk("midrst overflow", {31'd0, bus.overflow}, 32'd0);
      chk("midrst err", {31'd0, bus.err}, 32'd0);
      chk("midrst rd_data", bus.rd_data, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_main(1, 2, 6'b000001, 1'b0);
      check_t3("after-reset");

      // Narrow counters: A=1, N=0, L=6 doubles the single cell six times (64)
      @(posedge clk); #1;
      sbus.strand = '0; sbus.n_len = '0; sbus.l_len = 4'd6; sbus.start = 1'b1;
      @(posedge clk); #1;
      sbus.start = 1'b0;
      begin
         done_exp_t d;
         d.done_at = cyc + 6 * (1 * SA + 2);
         d.err = 1'b0; d.rv = 1'b1; d.ovf = 1'b1;
         q_sdone.push_back(d);
      end
      begin
         int k = 0;
         while (!sbus.done && k < 2000) begin
            @(negedge clk);
            k++;
         end
         if (!sbus.done) begin
            fail("small done timeout");
            if (q_sdone.size() > 0) q_sdone.delete(q_sdone.size() - 1);
         end
      end
      @(posedge clk); #1;
      sbus.rd_j = '0; sbus.rd_s = '0; srd_req = 1'b1;
      r.name = "small rd(0,0)"; r.kind = 0;
`ifdef SOFT_REC_SAT_EN
      r.val = 32'd15;
`else
      r.val = 32'd0;
`endif
      q_srd.push_back(r);
      @(posedge clk); #1;
      sbus.rd_j = 2'd1; r.name = "small rd j>N"; r.val = 32'd0;
      q_srd.push_back(r);
      @(posedge clk); #1;
      srd_req = 1'b0;
      repeat (3) @(posedge clk);

      if (q_done.size() != 0 || q_sdone.size() != 0 || q_rd.size() != 0 || q_srd.size() != 0)
         fail("scoreboard queues not drained");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
